// File: rtl/nonce_tx_queue_if.sv
// Bus between the nonce sources / serial_transmit and nonce_tx_queue.
// The queue is the master: it consumes the nonce strobes and drives the serial side.
//
// Handshake: serial_send is a one-cycle strobe. golden_nonce is valid with it and
// holds until serial_busy has risen and fallen again. The queue issues no further
// strobe before that fall, and only strobes when serial_busy is low.
interface nonce_tx_queue_if #(
    parameter int SLAVES = 2
);
    logic [SLAVES*32-1:0] slave_nonces;
    logic [SLAVES-1:0]    new_nonces;
    logic                 serial_busy;
    logic                 serial_send;
    logic [31:0]          golden_nonce;

    modport master (
        input  slave_nonces,
        input  new_nonces,
        input  serial_busy,
        output serial_send,
        output golden_nonce
    );

    modport slave (
        output slave_nonces,
        output new_nonces,
        output serial_busy,
        input  serial_send,
        input  golden_nonce
    );
endinterface

// File: rtl/nonce_tx_queue.sv
// Collects nonce strobes from several sources into per-source pending slots,
// round-robin arbitrates them into a FIFO and hands the words one at a time
// to serial_transmit over its send/busy handshake.
module nonce_tx_queue #(
    parameter int SLAVES     = 2,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    nonce_tx_queue_if.master    bus,
    output logic [DEPTH_LOG2:0] queue_count,
    output logic [7:0]          drop_count,
    output logic [1:0]          state_dbg
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IW    = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state;
    logic [SLAVES-1:0]     pend;
    logic [31:0]           pend_nonce [SLAVES];
    logic [IW-1:0]         rr_ptr;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    logic                  any_pend;
    logic [IW-1:0]         pick;
    logic [IW:0]           scan;
    logic                  push;
    logic                  pop;
    logic [8:0]            drops;
    logic [8:0]            drop_sum;

    assign state_dbg = state;

    // Fullness uses the registered count, so a pop in the same cycle does not free a slot.
    assign push = any_pend && (queue_count != (DEPTH_LOG2+1)'(DEPTH));
    assign pop  = (state == IDLE) && (queue_count != '0) && !bus.serial_busy;

    // Round-robin pick: first pending slot scanning upward from rr_ptr, wrapping mod SLAVES.
    always_comb begin
        any_pend = 1'b0;
        pick     = rr_ptr;
        scan     = '0;
        for (int j = 0; j < SLAVES; j++) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(j);
            if (scan >= (IW+1)'(SLAVES)) begin
                scan = scan - (IW+1)'(SLAVES);
            end
            if (!any_pend && pend[scan[IW-1:0]]) begin
                any_pend = 1'b1;
                pick     = scan[IW-1:0];
            end
        end
    end

    // Count strobes that land on a still-occupied slot that is not being moved out this cycle.
    always_comb begin
        drops = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (bus.new_nonces[i] && pend[i] && !(push && pick == IW'(i))) begin
                drops = drops + 9'd1;
            end
        end
        drop_sum = {1'b0, drop_count} + drops;
    end

    // Pending slots: a new strobe always wins; otherwise the slot empties when it is pushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
            for (int i = 0; i < SLAVES; i++) begin
                pend_nonce[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLAVES; i++) begin
                if (bus.new_nonces[i]) begin
                    pend[i]       <= 1'b1;
                    pend_nonce[i] <= bus.slave_nonces[i*32 +: 32];
                end else if (push && pick == IW'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of overwritten nonces.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_sum > 9'd255) begin
            drop_count <= 8'hFF;
        end else begin
            drop_count <= drop_sum[7:0];
        end
    end

    // FIFO pointers, occupancy and the round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
            rr_ptr      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (pick == IW'(SLAVES-1)) ? '0 : pick + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   queue_count <= queue_count + 1'b1;
                2'b01:   queue_count <= queue_count - 1'b1;
                default: queue_count <= queue_count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pend_nonce[pick];
        end
    end

    // Output FSM: pop one word, strobe send once, then follow busy up and down.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            bus.serial_send  <= 1'b0;
            bus.golden_nonce <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.golden_nonce <= mem[rd_ptr];
                        bus.serial_send  <= 1'b1;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    bus.serial_send <= 1'b0;
                    state           <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.serial_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.serial_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.serial_send <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule
